// File: rtl/mem_repair_responder.sv
// Fixed-latency backing memory for the L1D MSHR repair path.
// Serves one miss-fill at a time (merging a pending store word into the
// returned block) and absorbs dirty-block writebacks from the cache.
module mem_repair_responder #(
  parameter int ADDR_WIDTH    = 32,
  parameter int BLOCK_SIZE    = 128,
  parameter int NUM_BLOCKS    = 64,
  parameter int LATENCY       = 4,
  parameter int ROB_IDX_WIDTH = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     repair_req_i,
  input  logic [ADDR_WIDTH-1:0]    repair_req_addr_i,
  input  logic [31:0]              repair_req_data_i,
  input  logic [ROB_IDX_WIDTH-1:0] repair_req_rob_idx_i,
  input  logic                     repair_is_store_i,
  output logic                     repair_ack_o,
  output logic                     repair_complete_o,
  output logic [ADDR_WIDTH-1:0]    repair_addr_o,
  output logic [BLOCK_SIZE-1:0]    repair_data_o,
  output logic                     repair_dirty_o,
  output logic [ROB_IDX_WIDTH-1:0] repair_rob_idx_o,
  input  logic                     wb_en_i,
  input  logic [ADDR_WIDTH-1:0]    wb_addr_i,
  input  logic [BLOCK_SIZE-1:0]    wb_block_i,
  output logic                     wb_ready_o
);
  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int WORDS = BLOCK_SIZE / 32;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                          state;
  logic [CNT_W-1:0]                cnt;
  // Low until the first edge after reset release, so a request already
  // present when reset drops is not acked in that same cycle.
  logic                            armed;
  logic [ADDR_WIDTH-1:2]           lat_addr;
  logic [31:0]                     lat_data;
  logic [ROB_IDX_WIDTH-1:0]        lat_rob;
  logic                            lat_store;
  logic [NUM_BLOCKS-1:0][BLOCK_SIZE-1:0] mem;
  logic [WORDS-1:0][31:0]          fill_words;
  logic [IDX_W-1:0]                wb_idx;
  logic [IDX_W-1:0]                rd_idx;
  logic                            idle_rdy;
  logic                            unused_ok;

  assign idle_rdy     = armed && (state == IDLE);
  // Writeback has priority; a colliding request simply waits in IDLE.
  assign wb_ready_o   = idle_rdy & wb_en_i;
  assign repair_ack_o = idle_rdy & repair_req_i & ~wb_en_i;

  assign wb_idx = wb_addr_i[IDX_W+3:4];
  assign rd_idx = lat_addr[IDX_W+3:4];

  // Address bits that alias or select bytes are intentionally ignored.
  assign unused_ok = ^{wb_addr_i[ADDR_WIDTH-1:IDX_W+4], wb_addr_i[3:0],
                       repair_req_addr_i[1:0]};

  // Per-word fill mux: stored word replaces the addressed word on store misses.
  for (genvar w = 0; w < WORDS; w++) begin : g_word
    assign fill_words[w] = (lat_store && (lat_addr[3:2] == 2'(w))) ?
                           lat_data : mem[rd_idx][32*w +: 32];
  end

  // Backing array: cleared on reset, written only by accepted writebacks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)         mem <= '0;
    else if (wb_ready_o) mem[wb_idx] <= wb_block_i;
  end

  // Repair FSM with registered fill outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state             <= IDLE;
      cnt               <= '0;
      armed             <= 1'b0;
      lat_addr          <= '0;
      lat_data          <= '0;
      lat_rob           <= '0;
      lat_store         <= 1'b0;
      repair_complete_o <= 1'b0;
      repair_dirty_o    <= 1'b0;
      repair_addr_o     <= '0;
      repair_data_o     <= '0;
      repair_rob_idx_o  <= '0;
    end else begin
      armed             <= 1'b1;
      repair_complete_o <= 1'b0;
      case (state)
        IDLE: if (repair_ack_o) begin
          lat_addr  <= repair_req_addr_i[ADDR_WIDTH-1:2];
          lat_data  <= repair_req_data_i;
          lat_rob   <= repair_req_rob_idx_i;
          lat_store <= repair_is_store_i;
          cnt       <= CNT_W'(LATENCY - 1);
          state     <= BUSY;
        end
        BUSY: if (cnt == '0) begin
          repair_data_o     <= fill_words;
          repair_dirty_o    <= lat_store;
          repair_addr_o     <= {lat_addr[ADDR_WIDTH-1:4], 4'b0};
          repair_rob_idx_o  <= lat_rob;
          repair_complete_o <= 1'b1;
          state             <= RESP;
        end else begin
          cnt <= cnt - 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_repair_responder.sv
// Directed bench for mem_repair_responder: fills, writebacks, store merge,
// collision priority, back-to-back throughput and reset abort.
module tb_mem_repair_responder;
  localparam int LAT = 4;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         repair_req_i = 1'b0;
  logic [31:0]  repair_req_addr_i = '0;
  logic [31:0]  repair_req_data_i = '0;
  logic [5:0]   repair_req_rob_idx_i = '0;
  logic         repair_is_store_i = 1'b0;
  logic         repair_ack_o;
  logic         repair_complete_o;
  logic [31:0]  repair_addr_o;
  logic [127:0] repair_data_o;
  logic         repair_dirty_o;
  logic [5:0]   repair_rob_idx_o;
  logic         wb_en_i = 1'b0;
  logic [31:0]  wb_addr_i = '0;
  logic [127:0] wb_block_i = '0;
  logic         wb_ready_o;

  int nvec = 0;
  int nerr = 0;

  localparam logic [127:0] B1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [127:0] B4321 = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [127:0] BMRG = {32'd4, 32'hDEADBEEF, 32'd2, 32'd1};
  localparam logic [127:0] B2 = {32'hC0C0C0C0, 32'hC1C1C1C1, 32'hC2C2C2C2, 32'hC3C3C3C3};
  localparam logic [127:0] B3 = {32'h0BADF00D, 32'h12345678, 32'h9ABCDEF0, 32'h55AA55AA};

  mem_repair_responder #(
    .ADDR_WIDTH(32), .BLOCK_SIZE(128), .NUM_BLOCKS(64),
    .LATENCY(LAT), .ROB_IDX_WIDTH(6)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .repair_req_i(repair_req_i), .repair_req_addr_i(repair_req_addr_i),
    .repair_req_data_i(repair_req_data_i), .repair_req_rob_idx_i(repair_req_rob_idx_i),
    .repair_is_store_i(repair_is_store_i), .repair_ack_o(repair_ack_o),
    .repair_complete_o(repair_complete_o), .repair_addr_o(repair_addr_o),
    .repair_data_o(repair_data_o), .repair_dirty_o(repair_dirty_o),
    .repair_rob_idx_o(repair_rob_idx_o), .wb_en_i(wb_en_i),
    .wb_addr_i(wb_addr_i), .wb_block_i(wb_block_i), .wb_ready_o(wb_ready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one fill, wait for its completion pulse, and check every field.
  task automatic do_fill(input logic [31:0] a, input logic [31:0] d, input logic st,
                         input logic [5:0] rob, input logic [127:0] exp_d, input string nm);
    int n;
    repair_req_i = 1'b1; repair_req_addr_i = a; repair_req_data_i = d;
    repair_is_store_i = st; repair_req_rob_idx_i = rob;
    #1;
    nvec++;
    if (repair_ack_o !== 1'b1) begin nerr++; $display("FAIL %s ack: got %b want 1", nm, repair_ack_o); end
    tick();
    repair_req_i = 1'b0;
    n = 1;
    while (repair_complete_o !== 1'b1 && n < 20) begin tick(); n++; end
    nvec++;
    if (n !== LAT + 1) begin nerr++; $display("FAIL %s latency: got %0d want %0d", nm, n, LAT + 1); end
    nvec++;
    if (repair_data_o !== exp_d) begin nerr++; $display("FAIL %s data: got %h want %h", nm, repair_data_o, exp_d); end
    nvec++;
    if (repair_dirty_o !== st) begin nerr++; $display("FAIL %s dirty: got %b want %b", nm, repair_dirty_o, st); end
    nvec++;
    if (repair_addr_o !== {a[31:4], 4'b0}) begin nerr++; $display("FAIL %s addr: got %h want %h", nm, repair_addr_o, {a[31:4], 4'b0}); end
    nvec++;
    if (repair_rob_idx_o !== rob) begin nerr++; $display("FAIL %s rob: got %0d want %0d", nm, repair_rob_idx_o, rob); end
    tick();
    nvec++;
    if (repair_complete_o !== 1'b0) begin nerr++; $display("FAIL %s pulse_width: complete still %b", nm, repair_complete_o); end
  endtask

  task automatic do_wb(input logic [31:0] a, input logic [127:0] blk, input string nm);
    wb_en_i = 1'b1; wb_addr_i = a; wb_block_i = blk;
    #1;
    nvec++;
    if (wb_ready_o !== 1'b1) begin nerr++; $display("FAIL %s wb_ready: got %b want 1", nm, wb_ready_o); end
    tick();
    wb_en_i = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    repair_req_i = 1'b1; wb_en_i = 1'b1;
    #1;
    nvec++;
    if ({repair_ack_o, wb_ready_o, repair_complete_o, repair_dirty_o} !== 4'b0) begin
      nerr++; $display("FAIL reset_ctrl: got %b want 0000", {repair_ack_o, wb_ready_o, repair_complete_o, repair_dirty_o});
    end
    nvec++;
    if ({repair_addr_o, repair_data_o, repair_rob_idx_o} !== '0) begin
      nerr++; $display("FAIL reset_data: got %h/%h/%h want 0", repair_addr_o, repair_data_o, repair_rob_idx_o);
    end
    wb_en_i = 1'b0;
    rst_ni = 1'b1;
    #1;
    nvec++;
    if (repair_ack_o !== 1'b0) begin nerr++; $display("FAIL reset_release_ack: got %b want 0", repair_ack_o); end
    tick();
    nvec++;
    if (repair_ack_o !== 1'b1) begin nerr++; $display("FAIL first_idle_ack: got %b want 1", repair_ack_o); end
    repair_req_i = 1'b0;
    #1;
  endtask

  task automatic test_load_fill();
    do_fill(32'h40, 32'h0, 1'b0, 6'd5, 128'h0, "load_fill");
  endtask

  task automatic test_wb_fill();
    do_wb(32'h80, B1, "wb_fill");
    do_fill(32'h84, 32'h0, 1'b0, 6'd3, B1, "wb_fill");
  endtask

  task automatic test_store_merge();
    do_wb(32'h80, B4321, "merge_wb");
    do_fill(32'h88, 32'hDEADBEEF, 1'b1, 6'd7, BMRG, "store_merge");
    do_fill(32'h80, 32'h0, 1'b0, 6'd8, B4321, "merge_reload");
  endtask

  task automatic test_collision();
    wb_en_i = 1'b1; wb_addr_i = 32'hC0; wb_block_i = B2;
    repair_req_i = 1'b1; repair_req_addr_i = 32'hC4; repair_is_store_i = 1'b0;
    repair_req_rob_idx_i = 6'd9;
    #1;
    nvec++;
    if ({wb_ready_o, repair_ack_o} !== 2'b10) begin
      nerr++; $display("FAIL collision_prio: got wb_ready/ack %b want 10", {wb_ready_o, repair_ack_o});
    end
    tick();
    wb_en_i = 1'b0;
    do_fill(32'hC4, 32'h0, 1'b0, 6'd9, B2, "collision_fill");
  endtask

  task automatic test_back_to_back();
    int nack = 0, ncomp = 0, nwb = 0, wbc = -1;
    int ackc[2];
    ackc[0] = -1; ackc[1] = -1;
    repair_req_addr_i = 32'h40; repair_is_store_i = 1'b0;
    wb_addr_i = 32'h100; wb_block_i = B3;
    for (int c = 0; c < 18; c++) begin
      repair_req_i = (nack < 2);
      repair_req_rob_idx_i = (nack == 0) ? 6'd1 : 6'd2;
      wb_en_i = (nack >= 2) && (nwb == 0);
      #1;
      if (repair_ack_o === 1'b1) begin
        if (nack < 2) ackc[nack] = c;
        nack++;
      end
      if (wb_ready_o === 1'b1) begin wbc = c; nwb++; end
      if (repair_complete_o === 1'b1) begin
        nvec++;
        if (repair_rob_idx_o !== 6'(ncomp + 1)) begin
          nerr++; $display("FAIL b2b_rob: got %0d want %0d", repair_rob_idx_o, ncomp + 1);
        end
        ncomp++;
      end
      tick();
    end
    repair_req_i = 1'b0; wb_en_i = 1'b0;
    nvec++;
    if (nack !== 2) begin nerr++; $display("FAIL b2b_acks: got %0d want 2", nack); end
    nvec++;
    if (ackc[1] - ackc[0] !== LAT + 2) begin
      nerr++; $display("FAIL b2b_spacing: got %0d want %0d", ackc[1] - ackc[0], LAT + 2);
    end
    nvec++;
    if (nwb !== 1 || wbc - ackc[1] !== LAT + 2) begin
      nerr++; $display("FAIL b2b_wb_stall: got count %0d offset %0d want 1 and %0d", nwb, wbc - ackc[1], LAT + 2);
    end
    nvec++;
    if (ncomp !== 2) begin nerr++; $display("FAIL b2b_completes: got %0d want 2", ncomp); end
    do_fill(32'h108, 32'h0, 1'b0, 6'd11, B3, "b2b_wb_data");
  endtask

  task automatic test_reset_mid_busy();
    int seen = 0;
    do_wb(32'h140, B3, "rst_wb");
    repair_req_i = 1'b1; repair_req_addr_i = 32'h140; repair_is_store_i = 1'b0;
    repair_req_rob_idx_i = 6'd12;
    #1;
    nvec++;
    if (repair_ack_o !== 1'b1) begin nerr++; $display("FAIL rst_busy_ack: got %b want 1", repair_ack_o); end
    tick();
    repair_req_i = 1'b0;
    tick();
    rst_ni = 1'b0;
    #1;
    nvec++;
    if ({repair_complete_o, repair_dirty_o, repair_ack_o, wb_ready_o} !== 4'b0 ||
        {repair_addr_o, repair_data_o, repair_rob_idx_o} !== '0) begin
      nerr++; $display("FAIL rst_busy_outputs: got c%b d%b a%h data%h rob%0d want all 0",
                       repair_complete_o, repair_dirty_o, repair_addr_o, repair_data_o, repair_rob_idx_o);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 2) rst_ni = 1'b1;
      tick();
      if (repair_complete_o === 1'b1) seen++;
    end
    nvec++;
    if (seen !== 0) begin nerr++; $display("FAIL rst_busy_no_complete: got %0d pulses want 0", seen); end
    do_fill(32'h140, 32'h0, 1'b0, 6'd13, 128'h0, "rst_cleared");
  endtask

  initial begin
    test_reset();
    test_load_fill();
    test_wb_fill();
    test_store_merge();
    test_collision();
    test_back_to_back();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Global watchdog so the bench always reaches its summary.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_repair_responder.md
# mem_repair_responder

Memory-side responder for the L1 data cache's MSHR repair interface. It accepts one repair (miss-fill) request at a time from the MSHR and models fixed-latency backing memory. It returns the full 128-bit block, with a pending store word merged in and the block flagged dirty, plus the ROB index. It also absorbs dirty-block writebacks evicted by the data cache, so it serves as the backing store for cache bring-up and tests.

## Interface
- ADDR_WIDTH, 32, byte-address width
- BLOCK_SIZE, 128, block width in bits (16 bytes, 4 words); fixed at 128
- NUM_BLOCKS, 64, backing-store depth in blocks; power of two
- LATENCY, 4, BUSY cycles per repair; ≥1
- ROB_IDX_WIDTH, 6, ROB index width

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- repair_req_i  in  1  MSHR request valid; held until acked
- repair_req_addr_i  in  ADDR_WIDTH  miss byte address
- repair_req_data_i  in  32  store word (stores only)
- repair_req_rob_idx_i  in  ROB_IDX_WIDTH  requesting ROB entry
- repair_is_store_i  in  1  request is a store miss
- repair_ack_o  out  1  request accepted this cycle (combinational)
- repair_complete_o  out  1  one-cycle fill pulse
- repair_addr_o  out  ADDR_WIDTH  block-aligned fill address (addr[3:0]=0)
- repair_data_o  out  BLOCK_SIZE  fill block
- repair_dirty_o  out  1  fill contains a merged store
- repair_rob_idx_o  out  ROB_IDX_WIDTH  echoed ROB index
- wb_en_i  in  1  writeback valid; held until wb_ready_o
- wb_addr_i  in  ADDR_WIDTH  writeback byte address (block-aligned use only)
- wb_block_i  in  BLOCK_SIZE  evicted block
- wb_ready_o  out  1  writeback accepted this cycle (combinational)

## Operation
- Block index is addr[log2(NUM_BLOCKS)+3:4]. Upper bits are ignored (aliasing is allowed). Word offset is addr[3:2]; word w occupies bits [32w+31:32w]. addr[1:0] is ignored.
- Backing array: NUM_BLOCKS x BLOCK_SIZE, cleared to 0 on reset.
- FSM states are IDLE, BUSY, RESP.
  - IDLE: wb_ready_o = wb_en_i. On a writeback, array[idx(wb_addr_i)] <= wb_block_i at the edge, and the state stays IDLE.
  - IDLE: repair_ack_o = repair_req_i & ~wb_en_i. On ack, latch addr, data, rob_idx and is_store; load the counter with LATENCY-1; go to BUSY.
  - Writeback wins when both are valid in IDLE. The request stays pending and is acked on a later IDLE cycle, so a fill following a writeback to the same block returns the written data.
  - BUSY: decrement the counter each cycle. When the counter is 0, register the outputs: data = array[idx], with word addr[3:2] replaced by the latched store word if is_store; dirty = is_store. Then go to RESP.
  - RESP: repair_complete_o=1 for exactly one cycle, then go to IDLE.
  - repair_ack_o=0 and wb_ready_o=0 in BUSY and RESP.
- Store merges are never written to the array. The cache owns the dirty copy until it writes the block back.
- Only one request is outstanding at a time. There is no completion backpressure: the MSHR must sink repair_complete_o.

## Timing
- Reset values: state IDLE, counter 0. repair_complete_o, repair_dirty_o and repair_ack_o are 0. repair_addr_o, repair_data_o and repair_rob_idx_o are 0. wb_ready_o is 0. The array is all 0.
- A request acked in cycle T spends T+1..T+LATENCY in BUSY. repair_complete_o is high in cycle T+LATENCY+1. Fill latency is LATENCY+1 cycles from ack.
- The earliest next ack is cycle T+LATENCY+2. Steady-state throughput is 1 fill per LATENCY+2 cycles.
- repair_data_o, repair_addr_o, repair_dirty_o and repair_rob_idx_o are valid only while repair_complete_o=1. They hold their last values otherwise.
- A writeback accepted in cycle T is visible to any fill whose array read occurs at or after edge T+1.
- Reset asserted mid-BUSY or mid-RESP aborts immediately: no complete pulse, all outputs to reset values, the array is cleared. After deassertion, the first ack is possible on the first IDLE cycle.
- A request present in the same cycle rst_ni deasserts is not acked until the next clock edge has passed.

## Test plan
- Load fill: after reset, req addr 0x40, is_store=0, rob 5. Ack in cycle T. complete at T+5 with data 0, dirty 0, addr 0x40, rob 5.
- Writeback then fill: wb addr 0x80, block 0x4444_3333_2222_1111_...; one cycle later, load req 0x84. complete returns the identical block, dirty 0.
- Store merge: array block 0x80 = {w3..w0} = {4,3,2,1}. Store req 0x88, data 0xDEADBEEF. complete data {4,0xDEADBEEF,2,1}, dirty 1. A subsequent load to 0x80 returns {4,3,2,1}.
- Simultaneous wb_en_i and repair_req_i to the same block 0xC0 in IDLE: wb_ready_o=1 and repair_ack_o=0 that cycle. Ack follows the next cycle; fill returns the written block.
- Back-to-back: req held continuously for rob 1 then rob 2. Acks are LATENCY+2=6 cycles apart; ack=0 and wb_ready_o=0 throughout BUSY/RESP. A wb_en_i asserted during BUSY stalls until IDLE.
- Reset mid-BUSY: assert rst_ni=0 two cycles after ack. No repair_complete_o ever appears. Outputs are 0. A later load to the previously written block returns 0.
